// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch slice: reset vector,
// fetch FSM states and instruction field positions.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // FETCH: request pending at pc. DRAIN: one stale word still in flight.
  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned FUNC_MSB   = 5;
  localparam int unsigned FUNC_LSB   = 0;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_slot.sv
// Single instruction holding register with valid bit.
// Priority: reset, flush, load, consume.
module fetch_slot
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic        consume,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pc,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  // Slot register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= 1'b0;
      inst    <= '0;
      inst_pc <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      inst    <= load_inst;
      inst_pc <= load_pc;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word fetches at pc, holds one instruction for
// decode, and handles redirects including discarding one stale returning word.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  output logic        imem_ready,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus4
);

  fetch_state_e state, state_next;
  logic [31:0]  pc, pc_next;
  logic         slot_free;
  logic         accept;
  logic         slot_load;
  logic         slot_flush;
  logic         slot_consume;

  assign slot_free = !inst_valid || !stall;
  assign accept    = imem_valid && imem_ready;

  assign imem_addr = pc;
  assign opcode    = inst[OPCODE_MSB:OPCODE_LSB];
  assign func      = inst[FUNC_MSB:FUNC_LSB];
  assign pc_plus4  = inst_pc + 32'd4;

  // State and pc registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Handshake, next state, next pc and slot controls.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    imem_req     = 1'b0;
    imem_ready   = 1'b0;
    slot_load    = 1'b0;
    slot_flush   = 1'b0;
    slot_consume = inst_valid && !stall;

    case (state)
      FETCH: begin
        imem_req   = !reset;
        imem_ready = slot_free;
      end
      DRAIN: begin
        imem_ready = 1'b1;
      end
      default: begin
        imem_ready = 1'b1;
      end
    endcase

    if (redirect) begin
      // A beat accepted alongside the redirect is the only outstanding one,
      // so no drain is needed; otherwise one stale word is still to come.
      // In DRAIN this also leaves once the stale word arrives, since the
      // redirected address has not been requested yet.
      pc_next    = word_align(redirect_pc);
      slot_flush = 1'b1;
      state_next = accept ? FETCH : DRAIN;
    end else if (state == FETCH) begin
      if (accept) begin
        slot_load = 1'b1;
        pc_next   = pc + 32'd4;
      end
    end else begin
      if (accept) begin
        state_next = FETCH;
      end
    end
  end

  fetch_slot u_slot (
    .clk       (clk),
    .reset     (reset),
    .load      (slot_load),
    .flush     (slot_flush),
    .consume   (slot_consume),
    .load_inst (imem_data),
    .load_pc   (pc),
    .valid     (inst_valid),
    .inst      (inst),
    .inst_pc   (inst_pc)
  );

endmodule
